// File: rtl/dump_pkg.sv
// Shared types and widths for the architectural-register dump engine.
package dump_pkg;

    localparam int NUM_ARCH = 32;
    localparam int NUM_PHYS = 128;
    localparam int DATA_W   = 32;
    localparam int ARCH_W   = $clog2(NUM_ARCH);
    localparam int PHYS_W   = $clog2(NUM_PHYS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_Q,
        MAP,
        PRF,
        OUT
    } dump_state_t;

    typedef struct packed {
        logic [ARCH_W-1:0] arch;
        logic [PHYS_W-1:0] phys;
        logic [DATA_W-1:0] data;
        logic              last;
    } dump_beat_t;

    // Range walk wraps from the top architectural register back to 0.
    function automatic logic [ARCH_W-1:0] next_arch(input logic [ARCH_W-1:0] a);
        return (a == ARCH_W'(NUM_ARCH - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/arch_reg_dump_unit.sv
// Walks a range of arch regs: rename map -> PRF -> {arch,phys,data} beat stream.
// One beat per 4 cycles at full rate; beats hold until out_ready; abort wins over all but reset.
module arch_reg_dump_unit
    import dump_pkg::*;
#(
    parameter bit ZERO_X0 = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ARCH_W-1:0] req_first,
    input  logic [ARCH_W-1:0] req_last,
    input  logic              abort,
    input  logic              quiesce,
    output logic [ARCH_W-1:0] map_rd_idx,
    input  logic [PHYS_W-1:0] map_rd_phys,
    output logic [PHYS_W-1:0] prf_rd_idx,
    input  logic [DATA_W-1:0] prf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ARCH_W-1:0] out_arch,
    output logic [PHYS_W-1:0] out_phys,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    dump_state_t       state;
    dump_state_t       state_nx;
    logic [ARCH_W-1:0] cur;
    logic [ARCH_W-1:0] last_q;
    logic [PHYS_W-1:0] phys_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              at_last;
    dump_beat_t        beat;

    assign accept  = req_valid && (state == IDLE) && !abort;
    assign at_last = (cur == last_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = WAIT_Q;
            WAIT_Q:  if (quiesce)   state_nx = MAP;
            MAP:                    state_nx = PRF;
            PRF:                    state_nx = OUT;
            OUT:     if (out_ready) state_nx = at_last ? IDLE : WAIT_Q;
            default:                state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cur    <= '0;
            last_q <= '0;
            phys_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cur    <= req_first;
                last_q <= req_last;
            end
            if (!abort) begin
                if (state == MAP) phys_q <= map_rd_phys;
                if (state == PRF) data_q <= (ZERO_X0 && cur == '0) ? '0 : prf_rd_data;
                // A beat taken in the same cycle as abort is not advanced past.
                if (state == OUT && out_ready && !at_last) cur <= next_arch(cur);
            end
        end
    end

    always_comb begin
        beat       = '0;
        map_rd_idx = '0;
        prf_rd_idx = '0;
        if (state == MAP) map_rd_idx = cur;
        if (state == PRF) prf_rd_idx = phys_q;
        if (state == OUT) begin
            beat.arch = cur;
            beat.phys = phys_q;
            beat.data = data_q;
            beat.last = at_last;
        end
    end

    assign out_valid = (state == OUT);
    assign out_arch  = beat.arch;
    assign out_phys  = beat.phys;
    assign out_data  = beat.data;
    assign out_last  = beat.last;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
